sipo_deserializer: RTL

- Downstream consumer of the parallel-load serial shifter. Reassembles its serial bit stream into WIDTH-bit words.
- Presents each completed word on a one-deep output register with a valid/ready handshake.
- Flags overruns (word completed while output still held) and aborted frames (re-sync mid-word).
- Sits between the serial link and byte-wide consumers such as a FIFO or register file.

---
 rtl/serial_pkg.sv | 12 +
 rtl/sipo_deserializer_if.sv | 28 ++
 rtl/sipo_out_reg.sv | 45 ++++
 rtl/sipo_deserializer.sv | 96 +++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: deserializer FSM states and the
// default word width also used by the parallel-load shifter.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH = 8;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle: the serial bit stream on one side,
// the valid/ready word output and status flags on the other.
interface sipo_deserializer_if
    import serial_pkg::*;
    #(parameter int WIDTH = SER_WIDTH);

    logic             bit_in;
    logic             bit_valid;
    logic             sync;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    logic             frame_err;
    logic             clear_flags;

    // The master drives the serial stream and consumes words.
    modport master (
        output bit_in, bit_valid, sync, data_ready, clear_flags,
        input  data_out, data_valid, overrun, frame_err
    );

    modport slave (
        input  bit_in, bit_valid, sync, data_ready, clear_flags,
        output data_out, data_valid, overrun, frame_err
    );

endinterface

// File: rtl/sipo_out_reg.sv
// One-deep valid/ready holding register for completed words; a word that
// arrives while the register is full and not being drained sets overrun.
module sipo_out_reg
    import serial_pkg::*;
    #(parameter int WIDTH = SER_WIDTH)
    (
        input  logic             clk,
        input  logic             reset,
        input  logic             load,
        input  logic [WIDTH-1:0] word,
        input  logic             ready,
        input  logic             clear_flags,
        output logic [WIDTH-1:0] data,
        output logic             valid,
        output logic             overrun
    );

    logic accept;

    // Loading while the old word is consumed in the same cycle avoids a bubble.
    assign accept = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && accept) begin
                data  <= word;
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end

            // A fresh overrun takes priority over a clear in the same cycle.
            if (load && !accept) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Reassembles a serial bit stream into WIDTH-bit words, with optional sync
// framing, and hands them to a one-deep valid/ready output register.
module sipo_deserializer
    import serial_pkg::*;
    #(
        parameter int WIDTH        = SER_WIDTH,
        parameter bit MSB_FIRST    = 1'b1,
        parameter bit REQUIRE_SYNC = 1'b1
    )
    (
        input logic                 clk,
        input logic                 reset,
        sipo_deserializer_if.slave  bus
    );

    localparam int CW = $clog2(WIDTH);

    ser_state_t       state;
    ser_state_t       state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shifted;
    logic             frame_err_q;
    logic             frame_err_next;
    logic             word_done;

    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], bus.bit_in}
                               : {bus.bit_in, shreg[WIDTH-1:1]};

    // count holds the number of bits already in the word; the edge that sees
    // count == WIDTH-1 with a valid bit completes it.
    always_comb begin
        state_next     = state;
        count_next     = count;
        shreg_next     = shreg;
        frame_err_next = 1'b0;
        word_done      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.bit_valid && (bus.sync || !REQUIRE_SYNC)) begin
                    shreg_next = shifted;
                    count_next = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    shreg_next = shifted;
                    if (bus.sync && count != '0) begin
                        frame_err_next = 1'b1;
                        count_next     = CW'(1);
                    end else if (count == CW'(WIDTH - 1)) begin
                        word_done  = 1'b1;
                        count_next = '0;
                        state_next = REQUIRE_SYNC ? IDLE : SHIFT;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            shreg       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            shreg       <= shreg_next;
            frame_err_q <= frame_err_next;
        end
    end

    assign bus.frame_err = frame_err_q;

    sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (word_done),
        .word        (shifted),
        .ready       (bus.data_ready),
        .clear_flags (bus.clear_flags),
        .data        (bus.data_out),
        .valid       (bus.data_valid),
        .overrun     (bus.overrun)
    );

endmodule
